barret_arbiter_1453: RTL

Round-robin arbiter and sequencer that shares one pipelined Barrett reduction datapath (mod q = 1453) among NUM_REQ independent requesters. Each requester presents a 21-bit operand with a valid/ready handshake. The block grants one requester per cycle and pushes the operand, tagged with the requester index, through a 3-stage reduction pipeline. It returns the 11-bit residue and its tag on a single response port with backpressure. It sits between the NTT/multiplier front-ends and the shared modular-reduction resource.

---
 rtl/barret_1453_pkg.sv | 23 ++
 rtl/barret_pipe_1453.sv | 80 ++++++++
 rtl/barret_arbiter_1453.sv | 104 ++++++++++
 3 files changed

// File: rtl/barret_1453_pkg.sv
// Shared constants, operand/residue types and a plain-modulo reference
// for the mod-1453 Barrett reduction block.
package barret_1453_pkg;

  localparam int Q      = 1453;
  localparam int MU     = 2886;
  localparam int K      = 11;
  localparam int DIN_W  = 21;
  localparam int DOUT_W = 11;

  typedef logic [DIN_W-1:0]  din_t;
  typedef logic [DOUT_W-1:0] dout_t;

  localparam din_t           Q_DIN  = 21'd1453;
  localparam logic [DIN_W:0] MU_EXT = 22'd2886;

  function automatic dout_t barrett_ref(input din_t a);
    din_t v_r;
    v_r = a % Q_DIN;
    return v_r[DOUT_W-1:0];
  endfunction

endpackage

// File: rtl/barret_pipe_1453.sv
// Three-stage Barrett reduction pipeline (mod 1453) with a tag carried
// alongside each operand; one global enable stalls every stage at once.
module barret_pipe_1453
  import barret_1453_pkg::*;
#(
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  din_t             in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output dout_t            out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic             r_s1_valid;
  din_t             r_s1_a;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s2_valid;
  din_t             r_s2_a;
  dout_t            r_s2_t;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s3_valid;
  dout_t            r_s3_r;
  logic [TAG_W-1:0] r_s3_tag;

  dout_t w_t;
  din_t  w_r0;
  din_t  w_r1;
  dout_t w_r2;

  // The (a>>11)*MU product needs 22 bits; the quotient estimate fits in 11.
  assign w_t = dout_t'(({1'b0, r_s1_a >> K} * MU_EXT) >> K);

  // Estimate undershoots by at most two, so two corrective subtractions suffice.
  always_comb begin
    w_r0 = r_s2_a - ({{(DIN_W-DOUT_W){1'b0}}, r_s2_t} * Q_DIN);
    if (w_r0 >= Q_DIN) begin
      w_r1 = w_r0 - Q_DIN;
    end else begin
      w_r1 = w_r0;
    end
    w_r2 = dout_t'((w_r1 >= Q_DIN) ? (w_r1 - Q_DIN) : w_r1);
  end

  // Pipeline stage registers, all frozen together when en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_a     <= '0;
      r_s2_t     <= '0;
      r_s2_tag   <= '0;
      r_s3_valid <= 1'b0;
      r_s3_r     <= '0;
      r_s3_tag   <= '0;
    end else if (en) begin
      r_s1_valid <= in_valid;
      r_s1_a     <= in_data;
      r_s1_tag   <= in_tag;
      r_s2_valid <= r_s1_valid;
      r_s2_a     <= r_s1_a;
      r_s2_t     <= w_t;
      r_s2_tag   <= r_s1_tag;
      r_s3_valid <= r_s2_valid;
      r_s3_r     <= w_r2;
      r_s3_tag   <= r_s2_tag;
    end
  end

  assign out_valid = r_s3_valid;
  assign out_data  = r_s3_r;
  assign out_tag   = r_s3_tag;

endmodule

// File: rtl/barret_arbiter_1453.sv
// Round-robin arbiter feeding one shared Barrett mod-1453 pipeline from
// NUM_REQ requesters; the whole pipeline stalls on response backpressure.
module barret_arbiter_1453
  import barret_1453_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*DIN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output dout_t                    rsp_data,
  output logic [ID_W-1:0]          rsp_id
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [ID_W-1:0] w_gnt_idx;
  logic [ID_W-1:0] w_idx;
  logic            w_found;
  logic            w_advance;
  logic            w_accept;
  din_t            w_gnt_data;

  assign w_advance = !rsp_valid || rsp_ready;

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = ID_W'((int'(r_ptr) + off) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_idx;
      end else begin
        w_found   = w_found;
      end
    end
  end

  // One-hot ready, suppressed during reset and while the pipeline is stalled.
  always_comb begin
    if (rst_n && w_advance && w_found) begin
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_idx;
    end else begin
      req_ready = '0;
    end
  end

  assign w_accept = |(req_valid & req_ready);

  // Operand mux with constant slice offsets.
  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_gnt_data = req_data[i*DIN_W +: DIN_W];
      end else begin
        w_gnt_data = w_gnt_data;
      end
    end
  end

  // Pointer moves one past the winner, wrapping for non power-of-two counts.
  always_comb begin
    if (w_gnt_idx == ID_W'(NUM_REQ-1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_gnt_idx + ID_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_nxt;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  barret_pipe_1453 #(
    .TAG_W (ID_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (w_advance),
    .in_valid  (w_accept),
    .in_data   (w_gnt_data),
    .in_tag    (w_gnt_idx),
    .out_valid (rsp_valid),
    .out_data  (rsp_data),
    .out_tag   (rsp_id)
  );

endmodule
